// File: rtl/reg_byte_serializer.sv
// Serializes a 1/2/4-byte register value MSB-first onto a valid/ready byte link.
// Back-to-back words are accepted on the last-byte handshake, so the stream has no bubble.
module reg_byte_serializer #(
  parameter int WORD_W = 32,
  parameter int BYTE_W = 8
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [WORD_W-1:0] I,
  input  logic              Load,
  input  logic [1:0]        Size,
  output logic              InReady,
  input  logic              Flush,
  output logic [BYTE_W-1:0] ByteOut,
  output logic              OutValid,
  input  logic              OutReady,
  output logic              Last,
  output logic [2:0]        Remaining
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] sr_q, sr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              ready_q, ready_d;
  logic              byte_hs;
  logic              word_acc;

  // Left-align the selected bytes so the first one to send sits in the top byte.
  function automatic logic [WORD_W-1:0] align_word(input logic [WORD_W-1:0] w,
                                                   input logic [1:0]        sz);
    case (sz)
      2'b00:   return {w[7:0], 24'h000000};
      2'b01:   return {w[15:0], 16'h0000};
      default: return w;
    endcase
  endfunction

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'b00:   return 3'd1;
      2'b01:   return 3'd2;
      default: return 3'd4;
    endcase
  endfunction

  assign ByteOut   = sr_q[WORD_W-1 -: BYTE_W];
  assign OutValid  = (state_q == SEND);
  assign Remaining = cnt_q;
  assign Last      = OutValid & (cnt_q == 3'd1);
  // ready_q keeps InReady low until one clean edge has passed after reset.
  assign InReady   = ready_q & ((state_q == IDLE) | (OutValid & OutReady & Last));
  assign byte_hs   = OutValid & OutReady;
  assign word_acc  = Load & InReady;

  always_comb begin
    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    ready_d = 1'b1;
    if (Flush) begin
      state_d = IDLE;
      sr_d    = '0;
      cnt_d   = 3'd0;
    end else begin
      if (byte_hs) begin
        sr_d  = sr_q << BYTE_W;
        cnt_d = cnt_q - 3'd1;
        if (Last) state_d = IDLE;
      end
      // A word accepted on the final handshake overrides the shift above.
      if (word_acc) begin
        sr_d    = align_word(I, Size);
        cnt_d   = size_bytes(Size);
        state_d = SEND;
      end
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      sr_q    <= '0;
      cnt_q   <= 3'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: tb/tb_reg_byte_serializer.sv
// Bench for reg_byte_serializer: directed scenarios plus a randomized run
// checked against a byte-queue model of the link.
module tb_reg_byte_serializer;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] I = '0;
  logic        Load = 1'b0;
  logic [1:0]  Size = 2'b00;
  logic        InReady;
  logic        Flush = 1'b0;
  logic [7:0]  ByteOut;
  logic        OutValid;
  logic        OutReady = 1'b0;
  logic        Last;
  logic [2:0]  Remaining;

  int n_checks = 0;
  int n_pass   = 0;

  reg_byte_serializer #(.WORD_W(32), .BYTE_W(8)) dut (
    .Clock(Clock), .Reset(Reset), .I(I), .Load(Load), .Size(Size),
    .InReady(InReady), .Flush(Flush), .ByteOut(ByteOut), .OutValid(OutValid),
    .OutReady(OutReady), .Last(Last), .Remaining(Remaining)
  );

  always #5 Clock = ~Clock;

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic load_word(input logic [31:0] w, input logic [1:0] sz);
    I = w; Size = sz; Load = 1'b1;
    tick();
    Load = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; Load = 1'b1; I = $urandom; Size = 2'b10; OutReady = 1'b1;
    tick();
    #2;
    n_checks++; if (OutValid !== 1'b0) $display("FAIL reset_valid got %b want 0", OutValid); else n_pass++;
    n_checks++; if (Remaining !== 3'd0) $display("FAIL reset_rem got %0d want 0", Remaining); else n_pass++;
    n_checks++; if (ByteOut !== 8'h00) $display("FAIL reset_byte got %h want 00", ByteOut); else n_pass++;
    tick();
    Reset = 1'b0; Load = 1'b0;
    tick();
    #2;
    n_checks++; if (InReady !== 1'b1) $display("FAIL reset_inready got %b want 1", InReady); else n_pass++;
    n_checks++; if (OutValid !== 1'b0) $display("FAIL reset_no_byte got %b want 0", OutValid); else n_pass++;
  endtask

  task automatic test_four_byte();
    logic [7:0] exp [4];
    exp = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    OutReady = 1'b1;
    load_word(32'hDEADBEEF, 2'b10);
    for (int i = 0; i < 4; i++) begin
      #2;
      n_checks++; if (OutValid !== 1'b1) $display("FAIL t2_valid[%0d] got %b want 1", i, OutValid); else n_pass++;
      n_checks++; if (ByteOut !== exp[i]) $display("FAIL t2_byte[%0d] got %h want %h", i, ByteOut, exp[i]); else n_pass++;
      n_checks++; if (Remaining !== 3'(4 - i)) $display("FAIL t2_rem[%0d] got %0d want %0d", i, Remaining, 4 - i); else n_pass++;
      n_checks++; if (Last !== (i == 3)) $display("FAIL t2_last[%0d] got %b want %b", i, Last, i == 3); else n_pass++;
      tick();
    end
    #2;
    n_checks++; if (OutValid !== 1'b0) $display("FAIL t2_idle got %b want 0", OutValid); else n_pass++;
    tick();
  endtask

  task automatic test_short_sizes();
    OutReady = 1'b1;
    load_word(32'h123456A5, 2'b00);
    #2;
    n_checks++; if (ByteOut !== 8'hA5) $display("FAIL t3_b1 got %h want a5", ByteOut); else n_pass++;
    n_checks++; if (Last !== 1'b1) $display("FAIL t3_b1_last got %b want 1", Last); else n_pass++;
    n_checks++; if (Remaining !== 3'd1) $display("FAIL t3_b1_rem got %0d want 1", Remaining); else n_pass++;
    tick();
    #2;
    n_checks++; if (OutValid !== 1'b0) $display("FAIL t3_b1_idle got %b want 0", OutValid); else n_pass++;
    tick();
    load_word(32'hFFFF8001, 2'b01);
    #2;
    n_checks++; if (ByteOut !== 8'h80 || Last !== 1'b0 || Remaining !== 3'd2)
      $display("FAIL t3_b2_first got %h/%b/%0d want 80/0/2", ByteOut, Last, Remaining); else n_pass++;
    tick();
    #2;
    n_checks++; if (ByteOut !== 8'h01 || Last !== 1'b1 || Remaining !== 3'd1)
      $display("FAIL t3_b2_second got %h/%b/%0d want 01/1/1", ByteOut, Last, Remaining); else n_pass++;
    tick();
    #2;
    n_checks++; if (OutValid !== 1'b0) $display("FAIL t3_b2_idle got %b want 0", OutValid); else n_pass++;
    tick();
  endtask

  task automatic test_backpressure();
    logic pat [4];
    int   k;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};
    k = 0;
    OutReady = 1'b0;
    load_word(32'h01020304, 2'b10);
    for (int c = 0; c < 20 && k < 4; c++) begin
      OutReady = pat[c % 4];
      #2;
      n_checks++; if (OutValid !== 1'b1) $display("FAIL t4_valid[%0d] got %b want 1", c, OutValid); else n_pass++;
      n_checks++; if (ByteOut !== 8'(k + 1)) $display("FAIL t4_byte[%0d] got %h want %h", c, ByteOut, 8'(k + 1)); else n_pass++;
      n_checks++; if (Remaining !== 3'(4 - k)) $display("FAIL t4_rem[%0d] got %0d want %0d", c, Remaining, 4 - k); else n_pass++;
      if (OutReady) k++;
      tick();
    end
    OutReady = 1'b1;
    #2;
    n_checks++; if (OutValid !== 1'b0 || Remaining !== 3'd0)
      $display("FAIL t4_done got valid %b rem %0d want 0/0", OutValid, Remaining); else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp [8];
    exp = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    OutReady = 1'b1;
    I = 32'h11223344; Size = 2'b10; Load = 1'b1;
    tick();
    I = 32'hAABBCCDD;
    for (int i = 0; i < 8; i++) begin
      #2;
      n_checks++; if (OutValid !== 1'b1 || ByteOut !== exp[i])
        $display("FAIL t5_byte[%0d] got %b/%h want 1/%h", i, OutValid, ByteOut, exp[i]); else n_pass++;
      n_checks++; if (InReady !== (i == 3 || i == 7))
        $display("FAIL t5_inready[%0d] got %b want %b", i, InReady, (i == 3 || i == 7)); else n_pass++;
      tick();
      if (i == 3) Load = 1'b0;
    end
    #2;
    n_checks++; if (OutValid !== 1'b0) $display("FAIL t5_idle got %b want 0", OutValid); else n_pass++;
    tick();
  endtask

  task automatic test_flush();
    OutReady = 1'b1;
    load_word(32'hCAFEF00D, 2'b10);
    tick();
    tick();
    Flush = 1'b1; Load = 1'b1; I = $urandom; Size = 2'b10;
    #2;
    n_checks++; if (ByteOut !== 8'hF0 || Remaining !== 3'd2)
      $display("FAIL t6_pre got %h/%0d want f0/2", ByteOut, Remaining); else n_pass++;
    tick();
    Flush = 1'b0; Load = 1'b0;
    #2;
    n_checks++; if (OutValid !== 1'b0 || Remaining !== 3'd0 || ByteOut !== 8'h00)
      $display("FAIL t6_flushed got %b/%0d/%h want 0/0/00", OutValid, Remaining, ByteOut); else n_pass++;
    tick();
    #2;
    n_checks++; if (OutValid !== 1'b0) $display("FAIL t6_no_accept got %b want 0", OutValid); else n_pass++;
    Flush = 1'b1; Load = 1'b1; I = 32'h77; Size = 2'b00;
    #1;
    n_checks++; if (InReady !== 1'b1) $display("FAIL t6_idle_ready got %b want 1", InReady); else n_pass++;
    tick();
    Flush = 1'b0; Load = 1'b0;
    #2;
    n_checks++; if (OutValid !== 1'b0) $display("FAIL t6_flush_wins got %b want 0", OutValid); else n_pass++;
    tick();
    load_word(32'h0000009C, 2'b00);
    #2;
    n_checks++; if (ByteOut !== 8'h9C || Last !== 1'b1)
      $display("FAIL t6_after got %h/%b want 9c/1", ByteOut, Last); else n_pass++;
    tick();
    #2;
    n_checks++; if (OutValid !== 1'b0) $display("FAIL t6_after_idle got %b want 0", OutValid); else n_pass++;
    tick();
  endtask

  // Model: the sink-visible stream is just a queue of the current word's unsent bytes.
  task automatic test_random();
    logic [7:0] q [$];
    logic       e_valid, e_last, e_ready;
    logic [7:0] e_byte;
    logic [2:0] e_rem;
    int         n;
    for (int c = 0; c < 400; c++) begin
      Load     = 1'($urandom_range(0, 1));
      Size     = 2'($urandom_range(0, 3));
      I        = $urandom;
      OutReady = ($urandom_range(0, 9) < 7);
      Flush    = ($urandom_range(0, 19) == 0);
      #2;
      e_valid = (q.size() > 0);
      e_byte  = e_valid ? q[0] : 8'h00;
      e_rem   = 3'(q.size());
      e_last  = (q.size() == 1);
      e_ready = (q.size() == 0) || (OutReady && q.size() == 1);
      n_checks++; if (OutValid !== e_valid) $display("FAIL rnd_valid[%0d] got %b want %b", c, OutValid, e_valid); else n_pass++;
      n_checks++; if (ByteOut !== e_byte) $display("FAIL rnd_byte[%0d] got %h want %h", c, ByteOut, e_byte); else n_pass++;
      n_checks++; if (Remaining !== e_rem) $display("FAIL rnd_rem[%0d] got %0d want %0d", c, Remaining, e_rem); else n_pass++;
      n_checks++; if (Last !== e_last) $display("FAIL rnd_last[%0d] got %b want %b", c, Last, e_last); else n_pass++;
      n_checks++; if (InReady !== e_ready) $display("FAIL rnd_inready[%0d] got %b want %b", c, InReady, e_ready); else n_pass++;
      if (Flush) begin
        q.delete();
      end else begin
        if (e_valid && OutReady) void'(q.pop_front());
        if (Load && e_ready) begin
          n = (Size == 2'b00) ? 1 : (Size == 2'b01) ? 2 : 4;
          for (int b = n - 1; b >= 0; b--) q.push_back(I[8*b +: 8]);
        end
      end
      tick();
    end
    Load = 1'b0; Flush = 1'b0;
  endtask

  initial begin
    test_reset();
    test_four_byte();
    test_short_sizes();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
